// File: rtl/e203_exu_dpath_sched_if.sv
// Handshake and datapath bundle for the shared EXU datapath scheduler.
//   req_*     : four requesters (0=alu, 1=bjp, 2=agu, 3=mdv), packed per index
//   flush     : pipeline flush
//   dp_*      : issue to the shared combinational datapath and its result
//   rsp_*     : registered response with consumer back-pressure
//   lock_err  : one-cycle watchdog expiry pulse
// slave is the scheduler's view, master is the surrounding pipeline's view.
interface e203_exu_dpath_sched_if #(
  parameter int unsigned XLEN = 32
);
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0]        req_lock;
  logic [4*XLEN-1:0] req_op1;
  logic [4*XLEN-1:0] req_op2;
  logic [15:0]       req_opc;
  logic              flush;
  logic              dp_vld;
  logic [XLEN-1:0]   dp_op1;
  logic [XLEN-1:0]   dp_op2;
  logic [3:0]        dp_opc;
  logic [XLEN-1:0]   dp_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [XLEN-1:0]   rsp_data;
  logic              lock_err;

  modport slave (
    input  req_valid, req_lock, req_op1, req_op2, req_opc, flush, dp_res, rsp_ready,
    output req_ready, dp_vld, dp_op1, dp_op2, dp_opc, rsp_valid, rsp_id, rsp_data, lock_err
  );

  modport master (
    output req_valid, req_lock, req_op1, req_op2, req_opc, flush, dp_res, rsp_ready,
    input  req_ready, dp_vld, dp_op1, dp_op2, dp_opc, rsp_valid, rsp_id, rsp_data, lock_err
  );
endinterface

// File: rtl/e203_exu_dpath_sched.sv
// Shares one combinational datapath among four requesters. Round-robin grant
// in IDLE, exclusive ownership in LOCKED with a watchdog, and a one-deep
// registered response stage that reloads back-to-back.
//   clk, rst : clock and synchronous active-high reset
//   bus      : e203_exu_dpath_sched_if slave (requests, datapath, response)
module e203_exu_dpath_sched #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  e203_exu_dpath_sched_if.slave        bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_t          state;
  logic [1:0]      own;
  logic [1:0]      ptr;
  logic [7:0]      lock_cnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic            lock_err;

  logic            can_issue;
  logic            gnt_hit;
  logic            accept;
  logic [1:0]      gnt_idx;
  logic [1:0]      cand;
  logic [3:0]      req_ready_c;
  logic [XLEN-1:0] dp_op1_c;
  logic [XLEN-1:0] dp_op2_c;
  logic [3:0]      dp_opc_c;

  // Grant selection: owner only when locked, else first valid from ptr upward.
  always_comb begin
    can_issue = ~rst & ~bus.flush & (~rsp_valid | bus.rsp_ready);
    gnt_hit   = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    if (state == LOCKED) begin
      gnt_idx = own;
      gnt_hit = bus.req_valid[own];
    end else begin
      // Walk from farthest to nearest so the nearest valid candidate wins.
      for (int k = 3; k >= 0; k--) begin
        cand = ptr + 2'(k);
        if (bus.req_valid[cand]) begin
          gnt_hit = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    accept = can_issue & gnt_hit;
  end

  // One-hot ready and operand mux; operands are zero when nothing issues.
  always_comb begin
    req_ready_c = '0;
    dp_op1_c    = '0;
    dp_op2_c    = '0;
    dp_opc_c    = '0;
    if (accept) begin
      req_ready_c[gnt_idx] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (gnt_idx == 2'(k)) begin
          dp_op1_c = bus.req_op1[k*XLEN +: XLEN];
          dp_op2_c = bus.req_op2[k*XLEN +: XLEN];
          dp_opc_c = bus.req_opc[k*4 +: 4];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.dp_vld    = accept;
  assign bus.dp_op1    = dp_op1_c;
  assign bus.dp_op2    = dp_op2_c;
  assign bus.dp_opc    = dp_opc_c;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
  assign bus.lock_err  = lock_err;

  // Ownership FSM, round-robin pointer, watchdog and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own       <= '0;
      ptr       <= '0;
      lock_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (bus.flush) begin
        // Flush outranks any accept or watchdog expiry; ptr is kept.
        state     <= IDLE;
        lock_cnt  <= '0;
        rsp_valid <= 1'b0;
      end else begin
        if (accept) begin
          rsp_valid <= 1'b1;
          rsp_id    <= gnt_idx;
          rsp_data  <= bus.dp_res;
        end else if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (accept) begin
              if (bus.req_lock[gnt_idx]) begin
                state    <= LOCKED;
                own      <= gnt_idx;
                lock_cnt <= '0;
              end else begin
                ptr <= gnt_idx + 2'd1;
              end
            end
          end
          LOCKED: begin
            // An owner accept takes precedence over watchdog expiry.
            if (accept) begin
              lock_cnt <= '0;
              if (!bus.req_lock[own]) begin
                state <= IDLE;
                ptr   <= own + 2'd1;
              end
            end else if (lock_cnt == CNT_LAST) begin
              lock_err <= 1'b1;
              state    <= IDLE;
              ptr      <= own + 2'd1;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_dpath_sched.sv
// Self-checking bench for e203_exu_dpath_sched: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model and a
// response scoreboard.
module tb_e203_exu_dpath_sched;

  localparam int XLEN     = 32;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_exu_dpath_sched_if #(.XLEN(XLEN)) bus ();

  e203_exu_dpath_sched #(.XLEN(XLEN), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bench-side datapath: result depends on the low opcode bits.
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] opc);
    case (opc[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign bus.dp_res = alu(bus.dp_op1, bus.dp_op2, bus.dp_opc);

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t q[$];
  int   m_ptr    = 0;
  int   m_own    = 0;
  bit   m_locked = 1'b0;
  int   m_age    = 0;
  bit   m_err    = 1'b0;

  int n_cmp    = 0;
  int n_bad    = 0;
  int err_seen = 0;

  function automatic logic [31:0] op1_of(input int i);
    return bus.req_op1[i*XLEN +: XLEN];
  endfunction
  function automatic logic [31:0] op2_of(input int i);
    return bus.req_op2[i*XLEN +: XLEN];
  endfunction
  function automatic logic [3:0] opc_of(input int i);
    return bus.req_opc[i*4 +: 4];
  endfunction

  // Which requester the scheduler should grant right now (-1 = none).
  function automatic int exp_grant();
    if (rst || bus.flush) return -1;
    if (q.size() != 0 && !bus.rsp_ready) return -1;
    if (m_locked) return bus.req_valid[m_own] ? m_own : -1;
    for (int k = 0; k < 4; k++) begin
      if (bus.req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across a rising edge; pushes the expected response.
  task automatic model_step();
    int g;
    if (rst) begin
      m_locked = 1'b0; m_own = 0; m_ptr = 0; m_age = 0; m_err = 1'b0;
      q.delete();
    end else if (bus.flush) begin
      m_locked = 1'b0; m_age = 0; m_err = 1'b0;
      q.delete();
    end else begin
      g = exp_grant();
      m_err = 1'b0;
      if (g >= 0) begin
        q.push_back('{id: g, data: alu(op1_of(g), op2_of(g), opc_of(g))});
        if (m_locked) begin
          m_age = 0;
          if (!bus.req_lock[g]) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % 4;
          end
        end else if (bus.req_lock[g]) begin
          m_locked = 1'b1;
          m_own    = g;
          m_age    = 0;
        end else begin
          m_ptr = (g + 1) % 4;
        end
      end else if (m_locked) begin
        if (m_age == LOCK_MAX - 1) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
          m_ptr    = (m_own + 1) % 4;
          m_age    = 0;
        end else begin
          m_age++;
        end
      end
    end
  endtask

  // Monitor: compares everything the DUT presents, pops consumed responses.
  always @(negedge clk) begin
    int         g;
    logic [3:0] er;
    g  = exp_grant();
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("dp_vld",    64'(bus.dp_vld),    64'(g >= 0));
    chk("dp_op1",    64'(bus.dp_op1),    (g >= 0) ? 64'(op1_of(g)) : 64'd0);
    chk("dp_op2",    64'(bus.dp_op2),    (g >= 0) ? 64'(op2_of(g)) : 64'd0);
    chk("dp_opc",    64'(bus.dp_opc),    (g >= 0) ? 64'(opc_of(g)) : 64'd0);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rsp_id",   64'(bus.rsp_id),   64'(q[0].id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
    end
    chk("lock_err", 64'(bus.lock_err), 64'(m_err));
    if (bus.lock_err) err_seen++;
    if (q.size() != 0 && bus.rsp_ready && !rst && !bus.flush) void'(q.pop_front());
  end

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rr,
                       input logic fl, input logic r);
    rst           = r;
    bus.req_valid = v;
    bus.req_lock  = l;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    for (int k = 0; k < 4; k++) begin
      bus.req_op1[k*XLEN +: XLEN] = $urandom;
      bus.req_op2[k*XLEN +: XLEN] = $urandom;
      bus.req_opc[k*4 +: 4]       = 4'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic rr,
                     input logic fl, input logic r);
    drive(v, l, rr, fl, r);
    step();
  endtask

  initial begin
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);

    // All requesters valid: rotating grants.
    repeat (8) cyc(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

    // Requester 3 holds the lock while 0 keeps requesting.
    repeat (4) cyc(4'b1001, 4'b1000, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Requester 1 add 5+7, then back-pressure with everyone requesting.
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(4'b0010, 4'h0, 1'b1, 1'b0, 1'b0);
    bus.req_op1[1*XLEN +: XLEN] = 32'd5;
    bus.req_op2[1*XLEN +: XLEN] = 32'd7;
    bus.req_opc[1*4 +: 4]       = 4'd0;
    step();
    repeat (3) cyc(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

    // Requester 2 locks and goes quiet until the watchdog fires.
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (7) cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

    // Flush while locked with a stalled response.
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

    // Reset while locked with a stalled response.
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (3000) begin
      cyc(4'($urandom), 4'($urandom) & 4'($urandom), 1'(($urandom % 10) < 7),
          1'(($urandom % 25) == 0), 1'(($urandom % 300) == 0));
    end
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    chk("lock_err_seen", 64'(err_seen > 0), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
